ingress_batch_arbiter: RTL and testbench

- Shares one downstream write channel (packet-buffer SRAM writer) among NUM_PORTS ingress port front-ends.
- Each front-end delivers parsed 16-bit words with packet priority and destination port.
- Each port's words go into a private FIFO; a round-robin arbiter grants one port at a time and drains one batch (up to BATCH words, or to end of packet) per grant.
- Sits between the per-port ingress parsers and the buffer write logic.

---
 rtl/ingress_batch_arbiter_pkg.sv | 21 ++
 rtl/ingress_batch_arbiter_if.sv | 37 +++
 rtl/ingress_batch_arbiter_port_word_fifo.sv | 78 +++++++
 rtl/ingress_batch_arbiter.sv | 156 +++++++++++++++
 tb/tb_ingress_batch_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ingress_batch_arbiter_pkg.sv
// Shared types for the ingress batch arbiter: FIFO word entry, field widths
// and the arbiter FSM state encoding.
package ingress_batch_arbiter_pkg;

  localparam int DATA_W  = 16;
  localparam int PRIOR_W = 3;
  localparam int DEST_W  = 4;

  typedef struct packed {
    logic               eop;
    logic [PRIOR_W-1:0] prior;
    logic [DEST_W-1:0]  dest;
    logic [DATA_W-1:0]  data;
  } word_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ingress_batch_arbiter_if.sv
// Bundle of the per-port ingress word buses and the shared downstream write
// channel; slave is the arbiter side, master the front-end/writer side.
interface ingress_batch_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  import ingress_batch_arbiter_pkg::*;

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]         in_vld;
  logic [NUM_PORTS-1:0]         in_eop;
  logic [NUM_PORTS*DATA_W-1:0]  in_data;
  logic [NUM_PORTS*PRIOR_W-1:0] in_prior;
  logic [NUM_PORTS*DEST_W-1:0]  in_dest;
  logic                         out_rdy;
  logic                         out_vld;
  logic [PORT_W-1:0]            out_port;
  logic [DATA_W-1:0]            out_data;
  logic [PRIOR_W-1:0]           out_prior;
  logic [DEST_W-1:0]            out_dest;
  logic                         out_eop;
  logic                         out_last;
  logic [NUM_PORTS-1:0]         ovf;

  modport master (
    output in_vld, in_eop, in_data, in_prior, in_dest, out_rdy,
    input  out_vld, out_port, out_data, out_prior, out_dest, out_eop,
           out_last, ovf
  );

  modport slave (
    input  in_vld, in_eop, in_data, in_prior, in_dest, out_rdy,
    output out_vld, out_port, out_data, out_prior, out_dest, out_eop,
           out_last, ovf
  );

endinterface

// File: rtl/ingress_batch_arbiter_port_word_fifo.sv
// Per-port first-word fall-through word FIFO with occupancy, a count of
// buffered end-of-packet words and a sticky overflow flag.
module ingress_batch_arbiter_port_word_fifo
  import ingress_batch_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  word_entry_t      push_entry_i,
  input  logic             pop_i,
  output word_entry_t      head_o,
  output word_entry_t      head_next_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] eop_cnt_o,
  output logic             ovf_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  word_entry_t      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] eop_cnt_q;
  logic             ovf_q;
  logic             full;
  logic             pop_ok;
  logic             push_ok;
  logic             eop_in;
  logic             eop_out;

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  always_comb begin
    full    = (count_q == CNT_W'(FIFO_DEPTH));
    pop_ok  = pop_i && (count_q != '0);
    push_ok = push_i && (!full || pop_ok);
    eop_in  = push_ok && push_entry_i.eop;
    eop_out = pop_ok && head_o.eop;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      eop_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q   <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      eop_cnt_q <= eop_cnt_q + CNT_W'(eop_in) - CNT_W'(eop_out);
      if (push_i && !push_ok) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign head_next_o = mem_q[rd_ptr_q + AW'(1)];
  assign count_o     = count_q;
  assign eop_cnt_o   = eop_cnt_q;
  assign ovf_o       = ovf_q;

endmodule

// File: rtl/ingress_batch_arbiter.sv
// Round-robin batch arbiter: buffers each ingress port in its own FIFO and
// drains one batch (BATCH words or up to end of packet) per grant downstream.
module ingress_batch_arbiter
  import ingress_batch_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int BATCH      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  ingress_batch_arbiter_if.slave bus
);

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BEAT_W = (BATCH > 1) ? $clog2(BATCH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  arb_state_e        state_q;
  logic [PORT_W-1:0] gnt_q;
  logic [PORT_W-1:0] rr_q;
  logic [BEAT_W-1:0] beat_q;
  logic              out_vld_q;
  logic              out_last_q;
  word_entry_t       out_entry_q;

  word_entry_t       head [NUM_PORTS];
  word_entry_t       head_next [NUM_PORTS];
  logic [CNT_W-1:0]  count [NUM_PORTS];
  logic [CNT_W-1:0]  eop_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] ovf;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    word_entry_t push_entry;

    assign push_entry = '{
      eop:   bus.in_eop[p],
      prior: bus.in_prior[p*PRIOR_W +: PRIOR_W],
      dest:  bus.in_dest[p*DEST_W +: DEST_W],
      data:  bus.in_data[p*DATA_W +: DATA_W]
    };
    // A port asks for the channel once it holds a full batch or a whole packet.
    assign req[p] = (count[p] >= CNT_W'(BATCH)) || (eop_cnt[p] != '0);
    assign pop[p] = (state_q == BURST) && bus.out_rdy && (gnt_q == PORT_W'(p));

    ingress_batch_arbiter_port_word_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
    ) u_port_word_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (bus.in_vld[p]),
      .push_entry_i (push_entry),
      .pop_i        (pop[p]),
      .head_o       (head[p]),
      .head_next_o  (head_next[p]),
      .count_o      (count[p]),
      .eop_cnt_o    (eop_cnt[p]),
      .ovf_o        (ovf[p])
    );
  end

  logic              pick_found;
  logic [PORT_W-1:0] pick_idx;
  int                scan_idx;
  logic [PORT_W-1:0] scan_port;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    scan_port  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = int'(rr_q) + i;
      if (scan_idx >= NUM_PORTS) begin
        scan_idx = scan_idx - NUM_PORTS;
      end
      scan_port = PORT_W'(scan_idx);
      if (!pick_found && req[scan_port]) begin
        pick_found = 1'b1;
        pick_idx   = scan_port;
      end
    end
  end

  // The word loaded next is the new grant's head, or the word behind the
  // current head once that head is accepted.
  word_entry_t       entry_d;
  logic [BEAT_W-1:0] beat_d;
  logic              last_d;
  logic [PORT_W-1:0] rr_d;

  always_comb begin
    entry_d = head_next[gnt_q];
    beat_d  = beat_q + BEAT_W'(1);
    if (state_q == IDLE) begin
      entry_d = head[pick_idx];
      beat_d  = '0;
    end
    last_d = entry_d.eop || (beat_d == BEAT_W'(BATCH - 1));
    rr_d   = (gnt_q == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt_q + PORT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_q        <= '0;
      beat_q      <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_entry_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q     <= BURST;
            gnt_q       <= pick_idx;
            beat_q      <= beat_d;
            out_vld_q   <= 1'b1;
            out_entry_q <= entry_d;
            out_last_q  <= last_d;
          end
        end
        BURST: begin
          if (bus.out_rdy) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              rr_q        <= rr_d;
              out_vld_q   <= 1'b0;
              out_last_q  <= 1'b0;
              out_entry_q <= '0;
            end else begin
              beat_q      <= beat_d;
              out_entry_q <= entry_d;
              out_last_q  <= last_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_vld   = out_vld_q;
  assign bus.out_port  = gnt_q;
  assign bus.out_data  = out_entry_q.data;
  assign bus.out_prior = out_entry_q.prior;
  assign bus.out_dest  = out_entry_q.dest;
  assign bus.out_eop   = out_entry_q.eop;
  assign bus.out_last  = out_last_q;
  assign bus.ovf       = ovf;

endmodule

// File: tb/tb_ingress_batch_arbiter.sv
// Directed bench for ingress_batch_arbiter: batching, early eop, round-robin
// order, backpressure, overflow and mid-burst reset.
module tb_ingress_batch_arbiter;
  import ingress_batch_arbiter_pkg::*;

  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  ingress_batch_arbiter_if #(.NUM_PORTS(NP)) bus ();

  ingress_batch_arbiter #(
    .NUM_PORTS  (NP),
    .BATCH      (8),
    .FIFO_DEPTH (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          port;
    logic [15:0] data;
    logic [2:0]  prior;
    logic [3:0]  dest;
    logic        eop;
    logic        last;
  } obs_t;

  obs_t obs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Records every word transferred (out_vld && out_rdy) with its cycle stamp.
  task automatic collect(input int ncyc);
    obs_t o;
    for (int c = 0; c < ncyc; c++) begin
      if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) begin
        o.cyc   = c;
        o.port  = int'(bus.out_port);
        o.data  = bus.out_data;
        o.prior = bus.out_prior;
        o.dest  = bus.out_dest;
        o.eop   = bus.out_eop;
        o.last  = bus.out_last;
        obs.push_back(o);
      end
      tick();
    end
  endtask

  task automatic push_words(input int port, input int n, input logic [15:0] base,
                            input logic [2:0] prior, input logic [3:0] dest,
                            input bit eop_last);
    for (int i = 0; i < n; i++) begin
      bus.in_vld[port]           = 1'b1;
      bus.in_eop[port]           = eop_last && (i == n - 1);
      bus.in_data[port*16 +: 16] = base + 16'(i);
      bus.in_prior[port*3 +: 3]  = prior;
      bus.in_dest[port*4 +: 4]   = dest;
      tick();
    end
    bus.in_vld[port] = 1'b0;
    bus.in_eop[port] = 1'b0;
  endtask

  task automatic push_multi(input logic [NP-1:0] mask, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < NP; p++) begin
        if (mask[p]) begin
          bus.in_vld[p]           = 1'b1;
          bus.in_eop[p]           = 1'b0;
          bus.in_data[p*16 +: 16] = base + 16'(p * 256 + i);
          bus.in_prior[p*3 +: 3]  = 3'(p);
          bus.in_dest[p*4 +: 4]   = 4'(p + 8);
        end
      end
      tick();
    end
    bus.in_vld = '0;
    bus.in_eop = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    vectors++;
    if (bus.out_vld !== 1'b0 || bus.ovf !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_held: got out_vld=%b ovf=%b, expected 0 and 0000", bus.out_vld, bus.ovf);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.out_vld !== 1'b0 || bus.out_last !== 1'b0 || bus.out_eop !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got vld=%b last=%b eop=%b, expected 0 0 0",
               bus.out_vld, bus.out_last, bus.out_eop);
    end
    vectors++;
    if (bus.out_data !== 16'h0000 || bus.out_port !== 2'd0 || bus.out_prior !== 3'd0 || bus.out_dest !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_fields: got data=%h port=%0d prior=%0d dest=%0d, expected all 0",
               bus.out_data, bus.out_port, bus.out_prior, bus.out_dest);
    end
  endtask

  task automatic test_single_port();
    logic exp_last, exp_eop;
    obs.delete();
    bus.out_rdy = 1'b1;
    fork
      push_words(1, 10, 16'h1000, 3'd5, 4'd9, 1'b1);
      collect(40);
    join
    vectors++;
    if (obs.size() != 10) begin
      miscompares++;
      $display("FAIL single_count: got %0d words, expected 10", obs.size());
    end
    for (int i = 0; i < obs.size() && i < 10; i++) begin
      exp_last = (i == 7) || (i == 9);
      exp_eop  = (i == 9);
      vectors++;
      if (obs[i].data !== 16'h1000 + 16'(i) || obs[i].port != 1 || obs[i].prior !== 3'd5 ||
          obs[i].dest !== 4'd9 || obs[i].last !== exp_last || obs[i].eop !== exp_eop) begin
        miscompares++;
        $display("FAIL single_word%0d: got data=%h port=%0d prior=%0d dest=%0d last=%b eop=%b, expected data=%h port=1 prior=5 dest=9 last=%b eop=%b",
                 i, obs[i].data, obs[i].port, obs[i].prior, obs[i].dest, obs[i].last, obs[i].eop,
                 16'h1000 + 16'(i), exp_last, exp_eop);
      end
    end
    if (obs.size() >= 10) begin
      vectors++;
      if (obs[0].cyc != 9) begin
        miscompares++;
        $display("FAIL single_latency: first word at cycle %0d, expected 9", obs[0].cyc);
      end
      vectors++;
      if (obs[8].cyc - obs[7].cyc != 2) begin
        miscompares++;
        $display("FAIL single_idle_gap: gap %0d cycles, expected 2", obs[8].cyc - obs[7].cyc);
      end
    end
  endtask

  task automatic test_short_packet();
    obs.delete();
    fork
      push_words(0, 3, 16'h2000, 3'd2, 4'd4, 1'b1);
      collect(25);
    join
    vectors++;
    if (obs.size() != 3) begin
      miscompares++;
      $display("FAIL short_count: got %0d words, expected 3", obs.size());
    end
    for (int i = 0; i < obs.size() && i < 3; i++) begin
      vectors++;
      if (obs[i].data !== 16'h2000 + 16'(i) || obs[i].port != 0 ||
          obs[i].last !== (i == 2) || obs[i].eop !== (i == 2) || obs[i].cyc != 4 + i) begin
        miscompares++;
        $display("FAIL short_word%0d: got data=%h port=%0d last=%b eop=%b cyc=%0d, expected data=%h port=0 last=%b eop=%b cyc=%0d",
                 i, obs[i].data, obs[i].port, obs[i].last, obs[i].eop, obs[i].cyc,
                 16'h2000 + 16'(i), (i == 2), (i == 2), 4 + i);
      end
    end
    repeat (3) tick();
    vectors++;
    if (bus.out_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL short_no_regrant: got out_vld=%b, expected 0", bus.out_vld);
    end
  endtask

  task automatic test_round_robin();
    int order1[3] = '{0, 2, 3};
    int order2[2] = '{0, 3};
    int ep;
    apply_reset();
    obs.delete();
    fork
      push_multi(4'b1101, 8, 16'h3000);
      collect(45);
    join
    vectors++;
    if (obs.size() != 24) begin
      miscompares++;
      $display("FAIL rr1_count: got %0d words, expected 24", obs.size());
    end
    for (int i = 0; i < obs.size() && i < 24; i++) begin
      ep = order1[i / 8];
      vectors++;
      if (obs[i].port != ep || obs[i].data !== 16'h3000 + 16'(ep * 256 + i % 8) ||
          obs[i].last !== (i % 8 == 7) || obs[i].prior !== 3'(ep)) begin
        miscompares++;
        $display("FAIL rr1_word%0d: got port=%0d data=%h last=%b prior=%0d, expected port=%0d data=%h last=%b prior=%0d",
                 i, obs[i].port, obs[i].data, obs[i].last, obs[i].prior,
                 ep, 16'h3000 + 16'(ep * 256 + i % 8), (i % 8 == 7), ep);
      end
    end
    obs.delete();
    fork
      push_multi(4'b1001, 8, 16'h8000);
      collect(35);
    join
    vectors++;
    if (obs.size() != 16) begin
      miscompares++;
      $display("FAIL rr2_count: got %0d words, expected 16", obs.size());
    end
    for (int i = 0; i < obs.size() && i < 16; i++) begin
      ep = order2[i / 8];
      vectors++;
      if (obs[i].port != ep || obs[i].data !== 16'h8000 + 16'(ep * 256 + i % 8) ||
          obs[i].last !== (i % 8 == 7)) begin
        miscompares++;
        $display("FAIL rr2_word%0d: got port=%0d data=%h last=%b, expected port=%0d data=%h last=%b",
                 i, obs[i].port, obs[i].data, obs[i].last,
                 ep, 16'h8000 + 16'(ep * 256 + i % 8), (i % 8 == 7));
      end
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    int held = 0;
    push_words(1, 8, 16'h4000, 3'd1, 4'd2, 1'b0);
    for (int c = 0; c < 60 && accepted < 8; c++) begin
      tick();
      if (bus.out_vld === 1'b1) begin
        if (accepted == 2 && held < 4) begin
          held++;
          bus.out_rdy = 1'b0;
          vectors++;
          if (bus.out_data !== 16'h4002 || bus.out_last !== 1'b0 || bus.out_port !== 2'd1 ||
              bus.out_dest !== 4'd2) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got data=%h last=%b port=%0d dest=%0d, expected data=4002 last=0 port=1 dest=2",
                     held, bus.out_data, bus.out_last, bus.out_port, bus.out_dest);
          end
        end else begin
          vectors++;
          if (bus.out_data !== 16'h4000 + 16'(accepted) || bus.out_last !== (accepted == 7)) begin
            miscompares++;
            $display("FAIL bp_word%0d: got data=%h last=%b, expected data=%h last=%b",
                     accepted, bus.out_data, bus.out_last, 16'h4000 + 16'(accepted), (accepted == 7));
          end
          bus.out_rdy = 1'b1;
          accepted++;
        end
      end
    end
    vectors++;
    if (accepted != 8 || held != 4) begin
      miscompares++;
      $display("FAIL bp_totals: got accepted=%0d held=%0d, expected 8 and 4", accepted, held);
    end
    bus.out_rdy = 1'b1;
    repeat (3) tick();
    vectors++;
    if (bus.out_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_extra: got out_vld=%b after 8 words, expected 0", bus.out_vld);
    end
  endtask

  task automatic test_overflow();
    bus.out_rdy = 1'b0;
    push_words(2, 16, 16'h5000, 3'd3, 4'd7, 1'b0);
    vectors++;
    if (bus.ovf !== 4'b0000) begin
      miscompares++;
      $display("FAIL ovf_at16: got ovf=%b, expected 0000", bus.ovf);
    end
    push_words(2, 1, 16'h5010, 3'd3, 4'd7, 1'b0);
    vectors++;
    if (bus.ovf !== 4'b0100) begin
      miscompares++;
      $display("FAIL ovf_at17: got ovf=%b, expected 0100", bus.ovf);
    end
    obs.delete();
    bus.out_rdy = 1'b1;
    collect(30);
    vectors++;
    if (obs.size() != 16) begin
      miscompares++;
      $display("FAIL ovf_drain_count: got %0d words, expected 16", obs.size());
    end
    for (int i = 0; i < obs.size() && i < 16; i++) begin
      vectors++;
      if (obs[i].data !== 16'h5000 + 16'(i) || obs[i].port != 2 || obs[i].last !== (i % 8 == 7)) begin
        miscompares++;
        $display("FAIL ovf_word%0d: got data=%h port=%0d last=%b, expected data=%h port=2 last=%b",
                 i, obs[i].data, obs[i].port, obs[i].last, 16'h5000 + 16'(i), (i % 8 == 7));
      end
    end
    vectors++;
    if (bus.ovf !== 4'b0100) begin
      miscompares++;
      $display("FAIL ovf_sticky: got ovf=%b, expected 0100", bus.ovf);
    end
    apply_reset();
    vectors++;
    if (bus.ovf !== 4'b0000) begin
      miscompares++;
      $display("FAIL ovf_cleared: got ovf=%b, expected 0000", bus.ovf);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit found = 1'b0;
    bus.out_rdy = 1'b1;
    push_words(0, 8, 16'h6000, 3'd4, 4'd5, 1'b0);
    for (int c = 0; c < 30 && !found; c++) begin
      if (bus.out_vld === 1'b1 && bus.out_data === 16'h6003) begin
        found = 1'b1;
      end else begin
        tick();
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL midrst_timeout: word 4 not seen, expected data 6003");
    end
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_vld !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL midrst_async: got vld=%b last=%b data=%h, expected 0 0 0000",
               bus.out_vld, bus.out_last, bus.out_data);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    obs.delete();
    collect(20);
    vectors++;
    if (obs.size() != 0) begin
      miscompares++;
      $display("FAIL midrst_discard: got %0d words after reset, expected 0", obs.size());
    end
    fork
      push_words(3, 2, 16'h7000, 3'd6, 4'd1, 1'b1);
      collect(15);
    join
    vectors++;
    if (obs.size() != 2) begin
      miscompares++;
      $display("FAIL midrst_new_count: got %0d words, expected 2", obs.size());
    end else begin
      vectors++;
      if (obs[0].data !== 16'h7000 || obs[1].data !== 16'h7001 || obs[1].port != 3 ||
          obs[0].last !== 1'b0 || obs[1].last !== 1'b1 || obs[1].eop !== 1'b1) begin
        miscompares++;
        $display("FAIL midrst_new_words: got %h/%h port=%0d last=%b%b eop=%b, expected 7000/7001 port=3 last=01 eop=1",
                 obs[0].data, obs[1].data, obs[1].port, obs[0].last, obs[1].last, obs[1].eop);
      end
    end
  endtask

  initial begin
    bus.in_vld   = '0;
    bus.in_eop   = '0;
    bus.in_data  = '0;
    bus.in_prior = '0;
    bus.in_dest  = '0;
    bus.out_rdy  = 1'b1;
    test_reset();
    test_single_port();
    test_short_packet();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

endmodule
